// File: rtl/idma_obi_write_ot_pkg.sv
// Bus geometry and command type shared by the OBI write manager and its tracker.
package idma_obi_write_ot_pkg;

  localparam int unsigned DataWidth   = 32;
  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned LenWidth    = 8;
  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned OffsetWidth = $clog2(StrbWidth);

  // len counts remaining beats minus one, so the final beat sits at zero
  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [LenWidth-1:0]  len;
    logic [StrbWidth-1:0] first_be;
    logic [StrbWidth-1:0] last_be;
  } cmd_t;

endpackage

// File: rtl/idma_obi_wr_tracker.sv
// In-order response tracker: counts rvalids per command, folds errors and
// queues one completion per command.
module idma_obi_wr_tracker
  import idma_obi_write_ot_pkg::*;
#(
  parameter int unsigned CmdDepth = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [LenWidth-1:0] len_i,
  input  logic                rvalid_i,
  input  logic                err_i,
  input  logic                rsp_ready_i,
  output logic                rsp_valid_o,
  output logic                rsp_err_o
);

  localparam int unsigned PtrWidth = (CmdDepth > 1) ? $clog2(CmdDepth) : 1;
  localparam int unsigned CntWidth = $clog2(CmdDepth + 1);

  logic [LenWidth-1:0] len_mem [CmdDepth];
  logic [CmdDepth-1:0] err_mem;
  logic [PtrWidth-1:0] len_wr_q, len_rd_q, res_wr_q, res_rd_q;
  logic [CntWidth-1:0] res_cnt_q;
  logic [LenWidth-1:0] beat_cnt_q;
  logic                err_q;
  logic                err_acc, cmd_done, rsp_pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(CmdDepth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign err_acc     = err_q | err_i;
  assign cmd_done    = rvalid_i && (beat_cnt_q == len_mem[len_rd_q]);
  assign rsp_valid_o = (res_cnt_q != '0);
  assign rsp_err_o   = err_mem[res_rd_q];
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_wr_q   <= '0;
      len_rd_q   <= '0;
      res_wr_q   <= '0;
      res_rd_q   <= '0;
      res_cnt_q  <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      err_mem    <= '0;
    end else begin
      if (push_i) len_wr_q <= ptr_inc(len_wr_q);
      if (cmd_done) begin
        len_rd_q          <= ptr_inc(len_rd_q);
        res_wr_q          <= ptr_inc(res_wr_q);
        err_mem[res_wr_q] <= err_acc;
        beat_cnt_q        <= '0;
        err_q             <= 1'b0;
      end else if (rvalid_i) begin
        beat_cnt_q <= beat_cnt_q + LenWidth'(1);
        err_q      <= err_acc;
      end
      if (rsp_pop) res_rd_q <= ptr_inc(res_rd_q);
      case ({cmd_done, rsp_pop})
        2'b10:   res_cnt_q <= res_cnt_q + CntWidth'(1);
        2'b01:   res_cnt_q <= res_cnt_q - CntWidth'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) len_mem[len_wr_q] <= len_i;
  end

endmodule

// File: rtl/idma_obi_write_ot.sv
// OBI write manager: splits commands into word beats with first/last byte
// enables, keeps several beats outstanding and reports one completion per command.
module idma_obi_write_ot
  import idma_obi_write_ot_pkg::*;
#(
  parameter int unsigned NumOutstanding  = 4,
  parameter int unsigned CmdDepth        = 2,
  parameter bit          MaskInvalidData = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic [StrbWidth-1:0] cmd_first_be_i,
  input  logic [StrbWidth-1:0] cmd_last_be_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [DataWidth-1:0] buf_data_i,
  input  logic [StrbWidth-1:0] buf_valid_i,
  output logic [StrbWidth-1:0] buf_ready_o,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic                 obi_we_o,
  output logic [StrbWidth-1:0] obi_be_o,
  output logic [DataWidth-1:0] obi_wdata_o,
  input  logic                 obi_rvalid_i,
  input  logic                 obi_err_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_err_o,
  output logic                 busy_o
);

  // state | meaning
  // IDLE  | nothing to issue; takes a command while occupancy allows
  // ISSUE | issuing the beats of the latched command

  localparam int unsigned OutWidth = $clog2(NumOutstanding + 1);
  localparam int unsigned OccWidth = $clog2(CmdDepth + 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e               state_q, state_d;
  cmd_t                 cmd_q, cmd_d;
  logic                 first_q, first_d, hold_q;
  logic [OutWidth-1:0]  out_q;
  logic [OccWidth-1:0]  occ_q;
  logic [StrbWidth-1:0] beat_be;
  logic                 last_beat, beat_ok, grant, accept, rsp_hs;

  always_comb begin
    last_beat = (cmd_q.len == '0);
    unique case ({first_q, last_beat})
      2'b11:   beat_be = cmd_q.first_be & cmd_q.last_be;
      2'b10:   beat_be = cmd_q.first_be;
      2'b01:   beat_be = cmd_q.last_be;
      default: beat_be = '1;
    endcase

    // once raised, req is held by hold_q regardless of later buffer/credit changes
    beat_ok     = ((buf_valid_i & beat_be) == beat_be) && (out_q < OutWidth'(NumOutstanding));
    obi_req_o   = (state_q == ISSUE) && (hold_q || beat_ok);
    grant       = obi_req_o && obi_gnt_i;
    cmd_ready_o = (occ_q < OccWidth'(CmdDepth)) && ((state_q == IDLE) || (grant && last_beat));
    accept      = cmd_valid_i && cmd_ready_o;
    buf_ready_o = grant ? beat_be : '0;

    state_d = state_q;
    cmd_d   = cmd_q;
    first_d = first_q;
    if (grant) begin
      cmd_d.addr = cmd_q.addr + AddrWidth'(StrbWidth);
      cmd_d.len  = cmd_q.len - LenWidth'(1);
      first_d    = 1'b0;
      if (last_beat) state_d = IDLE;
    end
    if (accept) begin
      cmd_d.addr     = cmd_addr_i & ~AddrWidth'(StrbWidth - 1);
      cmd_d.len      = cmd_len_i;
      cmd_d.first_be = cmd_first_be_i;
      cmd_d.last_be  = cmd_last_be_i;
      first_d        = 1'b1;
      state_d        = ISSUE;
    end
  end

  always_comb begin
    obi_wdata_o = buf_data_i;
    for (int i = 0; i < StrbWidth; i++) begin
      if (MaskInvalidData && !beat_be[i]) obi_wdata_o[8*i +: 8] = 8'h00;
    end
  end

  assign obi_addr_o = cmd_q.addr;
  assign obi_be_o   = beat_be;
  assign obi_we_o   = 1'b1;
  assign rsp_hs     = rsp_valid_o && rsp_ready_i;
  assign busy_o     = (occ_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      first_q <= 1'b0;
      hold_q  <= 1'b0;
      out_q   <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      first_q <= first_d;
      hold_q  <= obi_req_o && !obi_gnt_i;
      case ({grant, obi_rvalid_i})
        2'b10:   out_q <= out_q + OutWidth'(1);
        2'b01:   out_q <= out_q - OutWidth'(1);
        default: ;
      endcase
      case ({accept, rsp_hs})
        2'b10:   occ_q <= occ_q + OccWidth'(1);
        2'b01:   occ_q <= occ_q - OccWidth'(1);
        default: ;
      endcase
    end
  end

  // occupancy also bounds the tracker, so its queues never overflow
  idma_obi_wr_tracker #(
    .CmdDepth (CmdDepth)
  ) i_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept),
    .len_i       (cmd_len_i),
    .rvalid_i    (obi_rvalid_i),
    .err_i       (obi_err_i),
    .rsp_ready_i (rsp_ready_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_err_o   (rsp_err_o)
  );

  assert property (@(posedge clk_i) disable iff (rst_i) !(obi_rvalid_i && (out_q == '0)));

endmodule

// File: tb/tb_idma_obi_write_ot.sv
// Scoreboard bench for the OBI write manager with randomized bus timing.
module tb_idma_obi_write_ot;
  import idma_obi_write_ot_pkg::*;

  localparam int unsigned NumOut = 2;
  localparam int unsigned Depth  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [3:0]  cmd_first_be = '0, cmd_last_be = '0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] buf_data;
  logic [3:0]  buf_valid, buf_ready;
  logic        obi_req, obi_gnt, obi_we;
  logic [31:0] obi_addr, obi_wdata;
  logic [3:0]  obi_be;
  logic        obi_rvalid, obi_err;
  logic        rsp_valid, rsp_ready, rsp_err, busy;

  always #5 clk = ~clk;

  idma_obi_write_ot #(
    .NumOutstanding  (NumOut),
    .CmdDepth        (Depth),
    .MaskInvalidData (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_addr_i     (cmd_addr),
    .cmd_len_i      (cmd_len),
    .cmd_first_be_i (cmd_first_be),
    .cmd_last_be_i  (cmd_last_be),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .buf_data_i     (buf_data),
    .buf_valid_i    (buf_valid),
    .buf_ready_o    (buf_ready),
    .obi_req_o      (obi_req),
    .obi_gnt_i      (obi_gnt),
    .obi_addr_o     (obi_addr),
    .obi_we_o       (obi_we),
    .obi_be_o       (obi_be),
    .obi_wdata_o    (obi_wdata),
    .obi_rvalid_i   (obi_rvalid),
    .obi_err_i      (obi_err),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_err_o      (rsp_err),
    .busy_o         (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    bit          last;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] buf_words[$];
  bit          beat_errs[$];
  bit          pending[$];
  bit          exp_rsp[$];

  int total = 0, bad = 0;
  int grants = 0, model_out = 0, coincide = 0;
  int rv_credit = -1;
  int gnt_pct = 100, rv_pct = 100, rdy_pct = 100;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int stall_left = 0;
  time last_grant_t = 0, acc_t = 0;
  bit buf_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_sample();
    @(negedge clk);
    #4;
  endtask

  task automatic wait_drive();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mask_word(input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++) if (!be[i]) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  // reference: beat i of a command goes to aligned start + 4*i, ends trimmed by first/last be
  task automatic push_expect(input logic [31:0] addr, input int len, input logic [3:0] fbe,
                             input logic [3:0] lbe, input logic [7:0] err_mask);
    beat_t       b;
    logic [31:0] w;
    logic [3:0]  be;
    bit          e;
    e = 0;
    for (int i = 0; i <= len; i++) begin
      w  = $urandom;
      be = 4'hF;
      if (i == 0) be = be & fbe;
      if (i == len) be = be & lbe;
      b.addr = {addr[31:2], 2'b00} + 32'(4 * i);
      b.be   = be;
      b.data = mask_word(w, be);
      b.last = (i == len);
      exp_beats.push_back(b);
      buf_words.push_back(w);
      beat_errs.push_back(err_mask[i]);
      e = e | err_mask[i];
    end
    exp_rsp.push_back(e);
  endtask

  task automatic send_cmd(input logic [31:0] addr, input int len, input logic [3:0] fbe,
                          input logic [3:0] lbe, input logic [7:0] err_mask,
                          input int budget, output bit taken);
    int n;
    n            = 0;
    taken        = 0;
    cmd_addr     = addr;
    cmd_len      = 8'(len);
    cmd_first_be = fbe;
    cmd_last_be  = lbe;
    cmd_valid    = 1'b1;
    while (n < budget && !taken) begin
      wait_sample();
      if (cmd_ready) begin
        taken = 1;
        acc_t = $time;
        push_expect(addr, len, fbe, lbe, err_mask);
      end
      n++;
    end
    wait_drive();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_beats.size() != 0 || exp_rsp.size() != 0 || busy) && n < budget) begin
      wait_sample();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s drain: timeout with %0d beats and %0d rsps still expected, required 0",
               name, exp_beats.size(), exp_rsp.size());
    end
    wait_drive();
  endtask

  // buffer: presents the head word, valid bits only accumulate until the pop
  initial begin
    logic [3:0] vld_acc;
    vld_acc   = '0;
    buf_data  = '0;
    buf_valid = '0;
    forever begin
      wait_drive();
      if (buf_pop) begin
        if (buf_words.size() != 0) void'(buf_words.pop_front());
        buf_pop = 0;
        vld_acc = '0;
      end
      if (buf_words.size() == 0) begin
        vld_acc   = '0;
        buf_valid = '0;
        buf_data  = $urandom;
      end else begin
        vld_acc   = vld_acc | (($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom));
        buf_valid = vld_acc;
        buf_data  = buf_words[0];
      end
    end
  end

  // OBI slave grant, decided on the falling edge from the presented request
  initial begin
    obi_gnt = 1'b0;
    forever begin
      @(negedge clk);
      obi_gnt = 1'b0;
      if (!rst && obi_req) begin
        if (stall_left > 0 && obi_addr == stall_addr) stall_left--;
        else obi_gnt = ($urandom_range(0, 99) < gnt_pct);
      end
    end
  end

  // OBI slave responses, in grant order
  initial begin
    obi_rvalid = 1'b0;
    obi_err    = 1'b0;
    forever begin
      wait_drive();
      obi_rvalid = 1'b0;
      obi_err    = 1'b0;
      if (!rst && pending.size() != 0 && rv_credit != 0 && $urandom_range(0, 99) < rv_pct) begin
        obi_rvalid = 1'b1;
        obi_err    = pending.pop_front();
        if (rv_credit > 0) rv_credit--;
      end
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      wait_drive();
      rsp_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // monitor / scoreboard
  initial begin
    beat_t       b;
    bit          held;
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_be;
    bit          e;
    held = 0;
    forever begin
      wait_sample();
      if (rst) begin
        held = 0;
      end else begin
        chk("outstanding", 32'(dut.out_q), 32'(model_out));
        if (held) begin
          chk("hold_req", 32'(obi_req), 32'd1);
          chk("hold_addr", obi_addr, h_addr);
          chk("hold_be", 32'(obi_be), 32'(h_be));
          chk("hold_wdata", obi_wdata, h_data);
        end
        if (obi_req && obi_gnt) begin
          if (exp_beats.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat: unexpected grant at addr %0h, expected no beat", obi_addr);
          end else begin
            b = exp_beats.pop_front();
            chk("beat_addr", obi_addr, b.addr);
            chk("beat_be", 32'(obi_be), 32'(b.be));
            chk("beat_wdata", obi_wdata, b.data);
            chk("buf_ready", 32'(buf_ready), 32'(b.be));
            chk("we", 32'(obi_we), 32'd1);
            if (b.last) last_grant_t = $time;
          end
          grants++;
          model_out++;
          buf_pop = 1;
          if (beat_errs.size() != 0) pending.push_back(beat_errs.pop_front());
          if (obi_rvalid) coincide++;
        end
        if (obi_rvalid) model_out--;
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp: unexpected completion err=%0b, expected none", rsp_err);
          end else begin
            e = exp_rsp.pop_front();
            chk("rsp_err", 32'(rsp_err), 32'(e));
          end
        end
        held   = obi_req && !obi_gnt;
        h_addr = obi_addr;
        h_be   = obi_be;
        h_data = obi_wdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          g0, len;
    logic [3:0]  fbe, lbe;
    logic [7:0]  em;

    repeat (3) wait_drive();
    wait_sample();
    chk("rst_req", 32'(obi_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_buf_ready", 32'(buf_ready), 32'd0);
    wait_drive();
    rst = 1'b0;

    // single partial beat
    send_cmd(32'h100, 0, 4'b1100, 4'b1111, 8'h00, 50, ok);
    chk("t1_accept", 32'(ok), 32'd1);
    drain(200, "t1");

    // four beats, grant withheld on the second
    stall_addr = 32'h4;
    stall_left = 3;
    send_cmd(32'h0, 3, 4'hF, 4'hF, 8'h00, 50, ok);
    drain(200, "t2");
    chk("t2_stall_seen", 32'(stall_left), 32'd0);

    // outstanding limit with responses withheld
    rv_credit = 0;
    g0 = grants;
    send_cmd(32'h200, 3, 4'hF, 4'hF, 8'h00, 50, ok);
    repeat (8) wait_sample();
    chk("t3_grants_cap", 32'(grants - g0), 32'd2);
    chk("t3_req_low", 32'(obi_req), 32'd0);
    for (int k = 3; k <= 4; k++) begin
      rv_credit = 1;
      repeat (6) wait_sample();
      chk("t3_grants_step", 32'(grants - g0), 32'(k));
    end
    rv_credit = -1;
    drain(200, "t3");

    // back-to-back commands, completions held, error on third beat
    rdy_pct = 0;
    send_cmd(32'h300, 1, 4'hF, 4'hF, 8'h00, 50, ok);
    send_cmd(32'h400, 1, 4'hF, 4'hF, 8'h01, 50, ok);
    chk("t4_b2b_accept", 32'(acc_t), 32'(last_grant_t));
    send_cmd(32'h500, 0, 4'hF, 4'hF, 8'h00, 15, ok);
    chk("t4_third_stalls", 32'(ok), 32'd0);
    wait_sample();
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    rdy_pct = 100;
    drain(200, "t4");

    // reset in the middle of a burst
    stall_addr = 32'h608;
    stall_left = 100;
    send_cmd(32'h600, 3, 4'hF, 4'hF, 8'h00, 50, ok);
    repeat (6) wait_sample();
    wait_drive();
    rst = 1'b1;
    wait_sample();
    wait_drive();
    exp_beats.delete();
    buf_words.delete();
    beat_errs.delete();
    pending.delete();
    exp_rsp.delete();
    model_out  = 0;
    buf_pop    = 0;
    stall_left = 0;
    rst = 1'b0;
    wait_sample();
    chk("rst_mid_req", 32'(obi_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    wait_drive();

    // address wrap
    send_cmd(32'hFFFF_FFFC, 1, 4'hF, 4'hF, 8'h00, 50, ok);
    drain(200, "t6");

    // randomized traffic
    gnt_pct = 60;
    rv_pct  = 50;
    rdy_pct = 70;
    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(0, 5);
      fbe = 4'($urandom_range(1, 15));
      lbe = 4'($urandom_range(1, 15));
      if (len == 0 && (fbe & lbe) == 4'h0) lbe = fbe;
      em = '0;
      for (int i = 0; i < 8; i++) em[i] = ($urandom_range(0, 7) == 0);
      send_cmd($urandom, len, fbe, lbe, em, 500, ok);
      chk("rand_accept", 32'(ok), 32'd1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) wait_drive();
    end
    drain(3000, "rand");
    chk("coincident_gnt_rvalid_seen", 32'(coincide > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
